// File: rtl/des_expand_keymix.sv
// DES f-function front end: E expansion of R, XOR with the round subkey, 2-entry elastic buffer.
// Optional per-entry chunk parity output enabled by defining DES_KEYMIX_PARITY_EN.
module des_expand_keymix (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_r,
  input  logic [47:0] i_subkey,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [47:0] o_sbox_in
`ifdef DES_KEYMIX_PARITY_EN
  ,
  output logic [7:0]  o_parity
`endif
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both high.
  // o_ready/o_valid decode only the registered count, so i_ready never reaches o_ready.

  // Chunk k (0-based) takes DES bits 4k..4k+5 of R, with 0 wrapping to 32 and 33 to 1.
  function automatic logic [47:0] f_expand(input logic [31:0] r);
    logic [47:0] e;
    int          n;
    e = '0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 6; j++) begin
        n = 4 * k + j;
        if (n == 0)  n = 32;
        if (n == 33) n = 1;
        e[47 - 6 * k - j] = r[32 - n];
      end
    end
    return e;
  endfunction

  logic [47:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic [47:0] w_mix;
  logic        w_accept;
  logic        w_deliver;

  assign w_mix     = f_expand(i_r) ^ i_subkey;
  assign o_ready   = (r_count != 2'd2) & ~i_rst;
  assign o_valid   = (r_count != 2'd0);
  assign w_accept  = i_valid & o_ready;
  assign w_deliver = o_valid & i_ready;
  assign o_sbox_in = o_valid ? r_mem[r_rd_ptr] : 48'h0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_mix;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_deliver) r_rd_ptr <= ~r_rd_ptr;
      case ({w_accept, w_deliver})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef DES_KEYMIX_PARITY_EN
  logic [7:0] r_par [2];
  logic [7:0] w_par;

  always_comb begin
    w_par = '0;
    for (int k = 0; k < 8; k++) w_par[7 - k] = ^w_mix[47 - 6 * k -: 6];
  end

  assign o_parity = o_valid ? r_par[r_rd_ptr] : 8'h00;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_par[0] <= '0;
      r_par[1] <= '0;
    end else if (i_flush) begin
      r_par[0] <= '0;
      r_par[1] <= '0;
    end else if (w_accept) begin
      r_par[r_wr_ptr] <= w_par;
    end
  end
`endif

endmodule

// File: tb/tb_des_expand_keymix.sv
// Directed bench for des_expand_keymix: E/XOR vectors, backpressure, streaming, flush, reset.
module tb_des_expand_keymix;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready_dut;
  logic [31:0] r_in;
  logic [47:0] k_in;
  logic        out_valid;
  logic        ds_ready;
  logic [47:0] sbox_in;
`ifdef DES_KEYMIX_PARITY_EN
  logic [7:0]  parity;
`endif

  int checks   = 0;
  int failures = 0;

  logic [47:0] exp_q[$];
  logic [47:0] exp_v;

  int e_tab [48] = '{32, 1, 2, 3, 4, 5,   4, 5, 6, 7, 8, 9,
                     8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                     16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                     24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

  des_expand_keymix dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_flush   (flush),
    .i_valid   (in_valid),
    .o_ready   (out_ready_dut),
    .i_r       (r_in),
    .i_subkey  (k_in),
    .o_valid   (out_valid),
    .i_ready   (ds_ready),
    .o_sbox_in (sbox_in)
`ifdef DES_KEYMIX_PARITY_EN
    ,
    .o_parity  (parity)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    e = '0;
    for (int p = 1; p <= 48; p++) e[48 - p] = r[32 - e_tab[p - 1]];
    return e ^ k;
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [47:0] k);
    in_valid = v;
    r_in     = r;
    k_in     = k;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ds_ready = 1'b0;
    drive(1'b0, 32'h0, 48'h0);
    step; step;
    chk("rst_ready", 48'(out_ready_dut), 48'h0);
    chk("rst_valid", 48'(out_valid), 48'h0);
    chk("rst_data", sbox_in, 48'h0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 48'(out_ready_dut), 48'h1);

    // single-bit E checks
    drive(1'b1, 32'h00000001, 48'h0);
    step;
    chk("e_lsb_valid", 48'(out_valid), 48'h1);
    chk("e_lsb_data", sbox_in, 48'h800000000002);
`ifdef DES_KEYMIX_PARITY_EN
    chk("e_lsb_par", 48'(parity), 48'h81);
`endif
    chk("one_ready", 48'(out_ready_dut), 48'h1);
    drive(1'b1, 32'h80000000, 48'h0);
    step;
    chk("full_ready", 48'(out_ready_dut), 48'h0);
    chk("full_head", sbox_in, 48'h800000000002);
    drive(1'b0, 32'h0, 48'h0);
    ds_ready = 1'b1;
    step;
    chk("e_msb_data", sbox_in, 48'h400000000001);
`ifdef DES_KEYMIX_PARITY_EN
    chk("e_msb_par", 48'(parity), 48'h81);
`endif
    step;
    chk("empty_valid", 48'(out_valid), 48'h0);
    chk("empty_data", sbox_in, 48'h0);
`ifdef DES_KEYMIX_PARITY_EN
    chk("empty_par", 48'(parity), 48'h0);
`endif

    // FIPS vector
    ds_ready = 1'b0;
    drive(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072);
    step;
    drive(1'b0, 32'h0, 48'h0);
    chk("fips_data", sbox_in, 48'h6117BA866527);
    chk("fips_chunk4", 48'(sbox_in[29:24]), 48'h3A);
    ds_ready = 1'b1;
    step;
    chk("fips_drain", 48'(out_valid), 48'h0);

    // reset mid-burst with two entries
    ds_ready = 1'b0;
    drive(1'b1, 32'h12345678, 48'hAAAA5555AAAA);
    step;
    drive(1'b1, 32'h9ABCDEF0, 48'h0F0F0F0F0F0F);
    step;
    drive(1'b0, 32'h0, 48'h0);
    chk("pre_rst_full", 48'(out_ready_dut), 48'h0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 48'(out_valid), 48'h0);
    chk("arst_data", sbox_in, 48'h0);
    chk("arst_ready", 48'(out_ready_dut), 48'h0);
    step;
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", 48'(out_ready_dut), 48'h1);
    drive(1'b1, 32'hCAFEBABE, 48'h123456789ABC);
    step;
    drive(1'b0, 32'h0, 48'h0);
    chk("arst_fresh", sbox_in, model(32'hCAFEBABE, 48'h123456789ABC));
    ds_ready = 1'b1;
    step;
    chk("arst_no_stale", 48'(out_valid), 48'h0);

    // backpressure: three beats, only two fit
    ds_ready = 1'b0;
    drive(1'b1, 32'h11111111, 48'h000000000001);
    step;
    drive(1'b1, 32'h22222222, 48'h000000000002);
    step;
    chk("bp_full", 48'(out_ready_dut), 48'h0);
    drive(1'b1, 32'h33333333, 48'h000000000003);
    step;
    chk("bp_hold_ready", 48'(out_ready_dut), 48'h0);
    chk("bp_hold_head", sbox_in, model(32'h11111111, 48'h000000000001));
    ds_ready = 1'b1;
    step;
    chk("bp_beat2", sbox_in, model(32'h22222222, 48'h000000000002));
    chk("bp_ready_again", 48'(out_ready_dut), 48'h1);
    step;
    drive(1'b0, 32'h0, 48'h0);
    chk("bp_beat3", sbox_in, model(32'h33333333, 48'h000000000003));
    step;
    chk("bp_drain", 48'(out_valid), 48'h0);

    // streaming, 16 random beats
    ds_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] rr;
      logic [47:0] kk;
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        chk("stream_valid", 48'(out_valid), 48'h1);
        chk("stream_data", sbox_in, exp_v);
      end
      rr = $urandom;
      kk = {16'($urandom_range(0, 65535)), 32'($urandom)};
      drive(1'b1, rr, kk);
      exp_q.push_back(model(rr, kk));
      step;
    end
    drive(1'b0, 32'h0, 48'h0);
    exp_v = exp_q.pop_front();
    chk("stream_last", sbox_in, exp_v);
    step;
    chk("stream_drain", 48'(out_valid), 48'h0);

    // flush at full with i_valid high
    ds_ready = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 48'h111111111111);
    step;
    drive(1'b1, 32'hFEEDFACE, 48'h222222222222);
    step;
    drive(1'b1, 32'h0BADF00D, 48'h333333333333);
    flush = 1'b1;
    step;
    flush = 1'b0;
    drive(1'b0, 32'h0, 48'h0);
    chk("flush_valid", 48'(out_valid), 48'h0);
    chk("flush_data", sbox_in, 48'h0);
    chk("flush_ready", 48'(out_ready_dut), 48'h1);
    step;
    chk("flush_stays_empty", 48'(out_valid), 48'h0);

    // flush drops a same-cycle accept
    drive(1'b1, 32'h01234567, 48'h0);
    step;
    drive(1'b1, 32'h76543210, 48'h0);
    flush = 1'b1;
    step;
    flush = 1'b0;
    drive(1'b0, 32'h0, 48'h0);
    chk("flush_drop_acc", 48'(out_valid), 48'h0);
    drive(1'b1, 32'h00000001, 48'hFFFFFFFFFFFF);
    step;
    drive(1'b0, 32'h0, 48'h0);
    chk("post_flush_data", sbox_in, 48'h7FFFFFFFFFFD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
